// File: rtl/toy_alu_redirect.sv
// Collects per-lane ALU mispredict reports, holds the oldest as a pending
// redirect, hands it to the frontend and pulses a backend flush request.
//
// state | meaning
// IDLE  | no redirect outstanding
// PEND  | redirect held, redirect_vld asserted toward the frontend
// FLUSH | redirect accepted, waiting for ROB flush_done (kill window)
module toy_alu_redirect #(
  parameter int ALU_NUM        = 2,
  parameter int INST_IDX_WIDTH = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALU_NUM-1:0]                alu_commit_en,
  input  logic [ALU_NUM-1:0]                alu_mispred,
  input  logic [ALU_NUM*INST_IDX_WIDTH-1:0] alu_inst_id,
  input  logic [ALU_NUM*ADDR_WIDTH-1:0]     alu_nxt_pc,
  output logic                              redirect_vld,
  input  logic                              redirect_rdy,
  output logic [ADDR_WIDTH-1:0]             redirect_pc,
  output logic [INST_IDX_WIDTH-1:0]         redirect_inst_id,
  output logic                              flush_req,
  input  logic                              flush_done,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              mispred_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic [INST_IDX_WIDTH-1:0] id_nxt;
  logic [ADDR_WIDTH-1:0]     pc_nxt;
  logic                      flush_nxt;
  logic                      cnt_inc;

  logic [INST_IDX_WIDTH-1:0] lane_id [ALU_NUM];
  logic [ADDR_WIDTH-1:0]     lane_pc [ALU_NUM];
  logic                      cand_vld;
  logic                      cand_older;
  logic [INST_IDX_WIDTH-1:0] cand_id;
  logic [ADDR_WIDTH-1:0]     cand_pc;

  // MSB is the wrap bit: a flipped wrap bit inverts the index ordering.
  function automatic logic older(input logic [INST_IDX_WIDTH-1:0] a,
                                 input logic [INST_IDX_WIDTH-1:0] b);
    if (a[INST_IDX_WIDTH-1] == b[INST_IDX_WIDTH-1])
      return a[INST_IDX_WIDTH-2:0] < b[INST_IDX_WIDTH-2:0];
    else
      return a[INST_IDX_WIDTH-2:0] > b[INST_IDX_WIDTH-2:0];
  endfunction

  for (genvar g = 0; g < ALU_NUM; g++) begin : g_lane
    assign lane_id[g] = alu_inst_id[g*INST_IDX_WIDTH +: INST_IDX_WIDTH];
    assign lane_pc[g] = alu_nxt_pc[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Strict compare keeps the lowest lane on identical ids.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    cand_pc  = '0;
    for (int i = 0; i < ALU_NUM; i++) begin
      if (alu_commit_en[i] && alu_mispred[i]) begin
        if (!cand_vld || older(lane_id[i], cand_id)) begin
          cand_vld = 1'b1;
          cand_id  = lane_id[i];
          cand_pc  = lane_pc[i];
        end
      end
    end
  end

  assign cand_older = cand_vld && older(cand_id, redirect_inst_id);

  always_comb begin
    state_nxt = state;
    id_nxt    = redirect_inst_id;
    pc_nxt    = redirect_pc;
    flush_nxt = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (cand_vld) begin
          id_nxt    = cand_id;
          pc_nxt    = cand_pc;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (redirect_rdy) begin
          flush_nxt = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = FLUSH;
        end
        if (cand_older) begin
          id_nxt    = cand_id;
          pc_nxt    = cand_pc;
          state_nxt = PEND;
        end
      end
      FLUSH: begin
        if (cand_older) begin
          id_nxt    = cand_id;
          pc_nxt    = cand_pc;
          state_nxt = PEND;
        end else if (flush_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      redirect_inst_id <= '0;
      redirect_pc      <= '0;
      flush_req        <= 1'b0;
      mispred_cnt      <= '0;
    end else begin
      state            <= state_nxt;
      redirect_inst_id <= id_nxt;
      redirect_pc      <= pc_nxt;
      flush_req        <= flush_nxt;
      if (cnt_inc) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

  assign redirect_vld = (state == PEND);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_toy_alu_redirect.sv
// Self-checking bench: table of per-cycle vectors, hand sequences for the
// handshake/older-candidate overlap, reset and counter wrap, plus a scoreboard.
module tb_toy_alu_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_commit_en;
  logic [1:0]  alu_mispred;
  logic [15:0] alu_inst_id;
  logic [63:0] alu_nxt_pc;
  logic        redirect_vld;
  logic        redirect_rdy;
  logic [31:0] redirect_pc;
  logic [7:0]  redirect_inst_id;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic [15:0] mispred_cnt;

  toy_alu_redirect dut (
    .clk(clk), .rst(rst),
    .alu_commit_en(alu_commit_en), .alu_mispred(alu_mispred),
    .alu_inst_id(alu_inst_id), .alu_nxt_pc(alu_nxt_pc),
    .redirect_vld(redirect_vld), .redirect_rdy(redirect_rdy),
    .redirect_pc(redirect_pc), .redirect_inst_id(redirect_inst_id),
    .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ce, mp;
    logic [7:0]  id0, id1;
    logic [31:0] pc0, pc1;
    logic        rdy, fd, acc;
    logic        e_vld, e_flush, e_busy;
    logic [7:0]  e_id;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct { logic [7:0] id; logic [31:0] pc; } acc_t;

  vec_t vecs[$];
  acc_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_en    = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic [1:0] ce, input logic [1:0] mp,
      input logic [7:0] id0, input logic [31:0] pc0,
      input logic [7:0] id1, input logic [31:0] pc1,
      input logic rdy, input logic fd, input logic acc,
      input logic vld, input logic fl, input logic bsy,
      input logic [7:0] id, input logic [31:0] pc, input logic [15:0] cnt);
    vec_t v;
    v.ce = ce; v.mp = mp; v.id0 = id0; v.id1 = id1; v.pc0 = pc0; v.pc1 = pc1;
    v.rdy = rdy; v.fd = fd; v.acc = acc;
    v.e_vld = vld; v.e_flush = fl; v.e_busy = bsy; v.e_id = id; v.e_pc = pc; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic [1:0] ce, input logic [1:0] mp,
                       input logic [7:0] id0, input logic [31:0] pc0,
                       input logic [7:0] id1, input logic [31:0] pc1,
                       input logic rdy, input logic fd);
    alu_commit_en = ce;
    alu_mispred   = mp;
    alu_inst_id   = {id1, id0};
    alu_nxt_pc    = {pc1, pc0};
    redirect_rdy  = rdy;
    flush_done    = fd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed handshake must match the next queued redirect.
  always @(negedge clk) begin
    if (sb_en && !rst && redirect_vld && redirect_rdy) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_handshake", 64'd1, 64'd0);
      end else begin
        acc_t a;
        a = sb_q.pop_front();
        chk("sb_id", 64'(redirect_inst_id), 64'(a.id));
        chk("sb_pc", 64'(redirect_pc), 64'(a.pc));
      end
    end
  end

  task automatic chk_out(input string tag, input logic vld, input logic fl, input logic bsy,
                         input logic [7:0] id, input logic [31:0] pc, input logic [15:0] cnt);
    chk({tag, "_vld"},   64'(redirect_vld), 64'(vld));
    chk({tag, "_flush"}, 64'(flush_req), 64'(fl));
    chk({tag, "_busy"},  64'(busy), 64'(bsy));
    chk({tag, "_id"},    64'(redirect_inst_id), 64'(id));
    chk({tag, "_pc"},    64'(redirect_pc), 64'(pc));
    chk({tag, "_cnt"},   64'(mispred_cnt), 64'(cnt));
  endtask

  initial begin
    logic [7:0]  prev_id;
    logic [31:0] prev_pc;
    //                 ce     mp     id0    pc0            id1    pc1            rdy fd acc  vld fl bsy id     pc             cnt
    // single lane0 mispredict, accept, flush, done
    vecs.push_back(mk(2'b01, 2'b01, 8'h05, 32'h8000_0100, 8'h00, 32'h0,          1, 0, 0,  1, 0, 1, 8'h05, 32'h8000_0100, 16'd0));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h05, 32'h8000_0100, 16'd1));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 0, 0,  0, 0, 1, 8'h05, 32'h8000_0100, 16'd1));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h05, 32'h8000_0100, 16'd1));
    // two lanes same cycle, older replacement, younger dropped, ignored lanes
    vecs.push_back(mk(2'b11, 2'b11, 8'h09, 32'hA000_0009, 8'h07, 32'hA000_0007, 0, 0, 0,  1, 0, 1, 8'h07, 32'hA000_0007, 16'd1));
    vecs.push_back(mk(2'b01, 2'b01, 8'h03, 32'hA000_0003, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h03, 32'hA000_0003, 16'd1));
    vecs.push_back(mk(2'b10, 2'b10, 8'h00, 32'h0,          8'h04, 32'hA000_0004, 0, 0, 0,  1, 0, 1, 8'h03, 32'hA000_0003, 16'd1));
    vecs.push_back(mk(2'b01, 2'b10, 8'h01, 32'hA000_0001, 8'h00, 32'hA000_0000, 0, 0, 0,  1, 0, 1, 8'h03, 32'hA000_0003, 16'd1));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h03, 32'hA000_0003, 16'd2));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h03, 32'hA000_0003, 16'd2));
    // wrap-bit age compare
    vecs.push_back(mk(2'b01, 2'b01, 8'h7E, 32'hB000_007E, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h7E, 32'hB000_007E, 16'd2));
    vecs.push_back(mk(2'b10, 2'b10, 8'h00, 32'h0,          8'h81, 32'hB000_0081, 0, 0, 0,  1, 0, 1, 8'h7E, 32'hB000_007E, 16'd2));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h7E, 32'hB000_007E, 16'd3));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h7E, 32'hB000_007E, 16'd3));
    vecs.push_back(mk(2'b01, 2'b01, 8'h81, 32'hB000_0081, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h81, 32'hB000_0081, 16'd3));
    vecs.push_back(mk(2'b10, 2'b10, 8'h00, 32'h0,          8'h7E, 32'hC000_007E, 0, 0, 0,  1, 0, 1, 8'h7E, 32'hC000_007E, 16'd3));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h7E, 32'hC000_007E, 16'd4));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h7E, 32'hC000_007E, 16'd4));
    // kill window: younger/equal dropped, older escapes without flush_done
    vecs.push_back(mk(2'b01, 2'b01, 8'h10, 32'hD000_0010, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h10, 32'hD000_0010, 16'd4));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h10, 32'hD000_0010, 16'd5));
    vecs.push_back(mk(2'b10, 2'b10, 8'h00, 32'h0,          8'h12, 32'hD000_0012, 0, 0, 0,  0, 0, 1, 8'h10, 32'hD000_0010, 16'd5));
    vecs.push_back(mk(2'b01, 2'b01, 8'h10, 32'hD000_0099, 8'h00, 32'h0,          0, 0, 0,  0, 0, 1, 8'h10, 32'hD000_0010, 16'd5));
    vecs.push_back(mk(2'b01, 2'b01, 8'h0F, 32'hD000_000F, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h0F, 32'hD000_000F, 16'd5));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  1, 0, 1, 8'h0F, 32'hD000_000F, 16'd5));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h0F, 32'hD000_000F, 16'd6));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h0F, 32'hD000_000F, 16'd6));
    // identical ids on both lanes: lane0 wins
    vecs.push_back(mk(2'b11, 2'b11, 8'h20, 32'hE000_0000, 8'h20, 32'hE000_0001, 0, 0, 0,  1, 0, 1, 8'h20, 32'hE000_0000, 16'd6));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h20, 32'hE000_0000, 16'd7));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h20, 32'hE000_0000, 16'd7));
    // flush_done together with an older candidate goes to PEND
    vecs.push_back(mk(2'b01, 2'b01, 8'h30, 32'hF000_0030, 8'h00, 32'h0,          0, 0, 0,  1, 0, 1, 8'h30, 32'hF000_0030, 16'd7));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h30, 32'hF000_0030, 16'd8));
    vecs.push_back(mk(2'b01, 2'b01, 8'h2F, 32'hF000_002F, 8'h00, 32'h0,          0, 1, 0,  1, 0, 1, 8'h2F, 32'hF000_002F, 16'd8));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          1, 0, 1,  0, 1, 1, 8'h2F, 32'hF000_002F, 16'd9));
    vecs.push_back(mk(2'b00, 2'b00, 8'h00, 32'h0,          8'h00, 32'h0,          0, 1, 0,  0, 0, 0, 8'h2F, 32'hF000_002F, 16'd9));

    rst = 1'b1;
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 16'd0);
    rst = 1'b0;

    prev_id = 8'h00;
    prev_pc = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ce, vecs[i].mp, vecs[i].id0, vecs[i].pc0, vecs[i].id1, vecs[i].pc1,
            vecs[i].rdy, vecs[i].fd);
      if (vecs[i].acc) sb_q.push_back('{prev_id, prev_pc});
      tick();
      chk_out($sformatf("row%0d", i), vecs[i].e_vld, vecs[i].e_flush, vecs[i].e_busy,
              vecs[i].e_id, vecs[i].e_pc, vecs[i].e_cnt);
      prev_id = vecs[i].e_id;
      prev_pc = vecs[i].e_pc;
    end

    // handshake overlapping an older candidate
    drive(2'b01, 2'b01, 8'h06, 32'h0000_0060, 8'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("ovl_pend", 1'b1, 1'b0, 1'b1, 8'h06, 32'h60, 16'd9);
    drive(2'b01, 2'b01, 8'h02, 32'h0000_0020, 8'h0, 32'h0, 1'b1, 1'b0);
    sb_q.push_back('{8'h06, 32'h60});
    tick();
    chk_out("ovl_hs", 1'b1, 1'b1, 1'b1, 8'h02, 32'h20, 16'd10);
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("ovl_hold", 1'b1, 1'b0, 1'b1, 8'h02, 32'h20, 16'd10);
    redirect_rdy = 1'b1;
    sb_q.push_back('{8'h02, 32'h20});
    tick();
    chk_out("ovl_acc2", 1'b0, 1'b1, 1'b1, 8'h02, 32'h20, 16'd11);
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("ovl_idle", 1'b0, 1'b0, 1'b0, 8'h02, 32'h20, 16'd11);

    // reset beats a handshake in progress
    drive(2'b01, 2'b01, 8'h40, 32'h0000_0400, 8'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("rst_pend", 1'b1, 1'b0, 1'b1, 8'h40, 32'h400, 16'd11);
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rst_hs", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 16'd0);
    rst = 1'b0;
    redirect_rdy = 1'b0;
    tick();
    chk_out("rst_after", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 16'd0);

    // counter wrap: one acceptance per cycle using ever-older ids
    sb_en = 1'b0;
    drive(2'b01, 2'b01, 8'h00, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 65536; k++) begin
      drive(2'b01, 2'b01, 8'(256 - (k % 256)), 32'(k), 8'h0, 32'h0, 1'b1, 1'b0);
      tick();
      if (k == 65535) chk("wrap_cnt_max", 64'(mispred_cnt), 64'hFFFF);
      if (k == 65536) begin
        chk("wrap_cnt_zero", 64'(mispred_cnt), 64'h0);
        chk("wrap_flush", 64'(flush_req), 64'h1);
        chk("wrap_vld", 64'(redirect_vld), 64'h1);
      end
    end
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("wrap_cnt_one", 64'(mispred_cnt), 64'h1);
    drive(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("wrap_idle", 64'(busy), 64'h0);

    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
